// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

    localparam logic SRC_INTR1 = 1'b0;
    localparam logic SRC_INTR2 = 1'b1;

    localparam int unsigned DEF_PC_W = 10;
    localparam logic [9:0]  DEF_VEC1 = 10'h3F0;
    localparam logic [9:0]  DEF_VEC2 = 10'h3F8;

    // Retire the most recently entered handler: intr1 can only nest above intr2.
    function automatic logic [1:0] clr_lowest(input logic [1:0] v);
        return v & (v - 2'd1);
    endfunction

endpackage

// File: rtl/intr_edge_det.sv
// Rising-edge detector with a sticky pending flag; a new edge wins over a clear.
module intr_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic clr,
    output logic pending
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev <= req;
            if (req && !prev)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Two-line interrupt controller producing one-cycle take pulses with fixed vectors.
// Define INTR_NESTING_EN to let intr1 preempt an active intr2 handler.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int unsigned          PC_W = DEF_PC_W,
    parameter logic [PC_W-1:0]      VEC1 = DEF_VEC1,
    parameter logic [PC_W-1:0]      VEC2 = DEF_VEC2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            intr1,
    input  logic            intr2,
    input  logic            ie_set,
    input  logic            ie_clr,
    input  logic            reti,
    input  logic            hold,
    output logic            take,
    output logic [PC_W-1:0] vector,
    output logic [1:0]      pending,
    output logic [1:0]      in_service,
    output logic            ie
);

    intr_state_t     state, state_n;
    logic            grant, grant_n;
    logic            take_n;
    logic [PC_W-1:0] vector_n;
    logic [1:0]      in_service_n;
    logic            ie_n;
    logic [1:0]      pend_clr;

    intr_edge_det u_edge1 (
        .clk     (clk),
        .reset   (reset),
        .req     (intr1),
        .clr     (pend_clr[SRC_INTR1]),
        .pending (pending[SRC_INTR1])
    );

    intr_edge_det u_edge2 (
        .clk     (clk),
        .reset   (reset),
        .req     (intr2),
        .clr     (pend_clr[SRC_INTR2]),
        .pending (pending[SRC_INTR2])
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= SRC_INTR1;
            take       <= 1'b0;
            vector     <= '0;
            in_service <= '0;
            ie         <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            take       <= take_n;
            vector     <= vector_n;
            in_service <= in_service_n;
            ie         <= ie_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        take_n       = 1'b0;
        vector_n     = '0;
        in_service_n = in_service;
        pend_clr     = '0;
        ie_n         = ie;
        if (ie_clr)
            ie_n = 1'b0;
        else if (ie_set)
            ie_n = 1'b1;

        unique case (state)
            IDLE: begin
                if (ie && (|pending) && !hold && (in_service == '0)) begin
                    state_n  = TAKE;
                    take_n   = 1'b1;
                    grant_n  = pending[SRC_INTR1] ? SRC_INTR1 : SRC_INTR2;
                    vector_n = pending[SRC_INTR1] ? VEC1 : VEC2;
                end
            end
            TAKE: begin
                pend_clr[grant]     = 1'b1;
                in_service_n[grant] = 1'b1;
                ie_n                = 1'b0;
                state_n             = SERVICE;
            end
            SERVICE: begin
                // reti outranks a nested entry so a handler never loses its return.
                if (reti && (in_service != '0)) begin
                    in_service_n = clr_lowest(in_service);
                    if (!ie_clr)
                        ie_n = 1'b1;
                    if (in_service_n == '0)
                        state_n = IDLE;
                end
`ifdef INTR_NESTING_EN
                else if ((in_service == 2'b10) && ie && pending[SRC_INTR1] && !hold) begin
                    state_n  = TAKE;
                    take_n   = 1'b1;
                    grant_n  = SRC_INTR1;
                    vector_n = VEC1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
